// File: rtl/imm_arb_pkg.sv
// imm_arb_pkg: shared definitions for the immediate arbiter/sequencer.
//   - state_t   : sequencer FSM encoding (IDLE=0, EXT=1, NEG=2, RESP=3, CHK=4)
//   - IMM_W_DEF : default immediate width
//   - DATA_W_DEF: default result width
//   - sext()    : sign-extend the low w bits of a value to SEXT_W bits
// CHK is only reached when the design is built with IMM_ARB_SELF_CHECK_EN.
package imm_arb_pkg;

    localparam int IMM_W_DEF  = 12;
    localparam int DATA_W_DEF = 32;
    // Working width of sext(); callers truncate the result to their DATA_W.
    localparam int SEXT_W     = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXT  = 3'd1,
        NEG  = 3'd2,
        RESP = 3'd3,
        CHK  = 3'd4
    } state_t;

    // Bit w-1 of v is the sign; every bit at or above w takes its value.
    // Done with masks so the sign position needs no variable bit-select.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                               input int unsigned        w);
        logic [SEXT_W-1:0] hi_mask;
        logic              sign;
        hi_mask = {SEXT_W{1'b1}} << w;
        sign    = |(v & (SEXT_W'(1) << (w - 1)));
        return sign ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   valid0, valid1 : request lines
//   accept         : arbiter may grant this cycle (sequencer idle)
//   last_in        : index granted most recently
//   grant          : index of the winner (meaningful when gnt_valid)
//   gnt_valid      : a grant is issued this cycle
// A lone requester always wins; on contention the one that was not last wins.
// Purely combinational; the last pointer lives in the instantiating block.
module rr_arb2 import imm_arb_pkg::*; (
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    input  logic last_in,
    output logic grant,
    output logic gnt_valid
);

    // NOTE: every output is assigned on every path, so no latch can be inferred.
    always_comb begin
        grant     = (valid0 && valid1) ? ~last_in : valid1;
        gnt_valid = accept && (valid0 || valid1);
    end

endmodule

// File: rtl/imm_arb.sv
// imm_arb: two-requester round-robin arbiter in front of a shared
// sign-extend / negate datapath, answering on a single tagged response channel.
//   clk, rst                     : clock, synchronous active-high reset
//   req{0,1}_valid/ready         : request handshake (ready is combinational)
//   req{0,1}_imm, req{0,1}_neg   : immediate and "return negated" flag
//   rsp_valid/ready              : response handshake
//   rsp_data, rsp_id             : result and index of the answered requester
//   busy                         : high whenever the sequencer is not IDLE
//   chk_err                      : only with IMM_ARB_SELF_CHECK_EN; set when
//                                  sext(imm) + negated result is non-zero
// Optional build macro: IMM_ARB_SELF_CHECK_EN (adds CHK state and chk_err).
module imm_arb import imm_arb_pkg::*; #(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic              req0_neg,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic              req1_neg,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
`ifdef IMM_ARB_SELF_CHECK_EN
    output logic              chk_err,
`endif
    output logic              busy
);

    state_t             state;
    logic               last;
    logic               grant;
    logic               gnt_valid;
    logic [IMM_W-1:0]   imm_q;
    logic               neg_q;
    logic               id_q;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  imm_ext;

    assign imm_ext = DATA_W'(sext(SEXT_W'(imm_q), IMM_W));

    rr_arb2 u_arb (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .accept    (state == IDLE),
        .last_in   (last),
        .grant     (grant),
        .gnt_valid (gnt_valid)
    );

    // A grant only exists while IDLE, so ready doubles as the accept strobe.
    assign req0_ready = gnt_valid && !grant;
    assign req1_ready = gnt_valid &&  grant;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
`ifdef IMM_ARB_SELF_CHECK_EN
            chk_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        last  <= grant;
                        state <= EXT;
                        busy  <= 1'b1;
                    end
                end
                EXT: begin
                    state <= neg_q ? NEG : RESP;
`ifdef IMM_ARB_SELF_CHECK_EN
                    // Plain requests never visit CHK; report them clean.
                    chk_err <= 1'b0;
`endif
                end
                NEG: begin
`ifdef IMM_ARB_SELF_CHECK_EN
                    state <= CHK;
`else
                    state <= RESP;
`endif
                end
`ifdef IMM_ARB_SELF_CHECK_EN
                CHK: begin
                    // x + (-x) must wrap to zero for a correct negation.
                    chk_err <= (imm_ext + acc) != '0;
                    state   <= RESP;
                end
`endif
                RESP: begin
                    // First RESP cycle loads the response registers; they then
                    // hold until the consumer takes them.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= acc;
                        rsp_id    <= id_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always written before
    // being read, and a dropped request simply leaves stale, unused contents.
    always_ff @(posedge clk) begin
        if (gnt_valid) begin
            imm_q <= grant ? req1_imm : req0_imm;
            neg_q <= grant ? req1_neg : req0_neg;
            id_q  <= grant;
        end
        if (state == EXT) begin
            acc <= imm_ext;
        end else if (state == NEG) begin
            acc <= ~acc + DATA_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_arb.sv
// tb_imm_arb: self-checking bench for imm_arb.
// Directed table of request rounds, hand-written reset-during-NEG sequence,
// then randomized rounds scored against a behavioural model.
module tb_imm_arb;

    localparam int IMM_W  = 12;
    localparam int DATA_W = 32;
`ifdef IMM_ARB_SELF_CHECK_EN
    localparam int LAT_NEG = 4;
`else
    localparam int LAT_NEG = 3;
`endif
    localparam int LAT_PLAIN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_neg;
    logic              req1_valid, req1_ready, req1_neg;
    logic [IMM_W-1:0]  req0_imm, req1_imm;
    logic              rsp_valid, rsp_ready, rsp_id, busy;
    logic [DATA_W-1:0] rsp_data;
`ifdef IMM_ARB_SELF_CHECK_EN
    logic              chk_err;
`endif

    always #5 clk = ~clk;

    imm_arb #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_neg   (req0_neg),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_neg   (req1_neg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
`ifdef IMM_ARB_SELF_CHECK_EN
        .chk_err    (chk_err),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic             v0;
        logic             v1;
        logic [IMM_W-1:0] i0;
        logic [IMM_W-1:0] i1;
        logic             n0;
        logic             n1;
        int               stall;
        logic             exp_id;
        logic [31:0]      exp_data;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic last_m;
    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result as the architecture defines it: signed value of the immediate,
    // optionally negated, wrapped to 32 bits.
    function automatic logic [31:0] model(input logic [IMM_W-1:0] imm, input logic neg);
        int v;
        v = int'(imm);
        if (v >= (1 << (IMM_W - 1))) v = v - (1 << IMM_W);
        if (neg) v = -v;
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete request/response round, starting and ending in IDLE.
    task automatic run_round(input string tag, input vec_t t);
        int   cnt;
        int   lat;
        logic neg_sel;
        req0_valid = t.v0;  req0_imm = t.i0;  req0_neg = t.n0;
        req1_valid = t.v1;  req1_imm = t.i1;  req1_neg = t.n1;
        rsp_ready  = (t.stall == 0);
        #1;
        check({tag, " grant"}, 64'({req1_ready, req0_ready}), t.exp_id ? 64'h2 : 64'h1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, " busy_run"}, 64'(busy), 64'h1);
        neg_sel = t.exp_id ? t.n1 : t.n0;
        lat     = neg_sel ? LAT_NEG : LAT_PLAIN;
        cnt     = 0;
        while (!rsp_valid && cnt < 12) begin
            tick();
            cnt++;
        end
        check({tag, " latency"}, 64'(cnt), 64'(lat));
        check({tag, " rsp_data"}, 64'(rsp_data), 64'(t.exp_data));
        check({tag, " rsp_id"}, 64'(rsp_id), 64'(t.exp_id));
`ifdef IMM_ARB_SELF_CHECK_EN
        check({tag, " chk_err"}, 64'(chk_err), 64'h0);
`endif
        for (int s = 0; s < t.stall; s++) begin
            // Fresh requests during RESP must not be accepted.
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            tick();
            check({tag, " stall_valid"}, 64'(rsp_valid), 64'h1);
            check({tag, " stall_data"}, 64'(rsp_data), 64'(t.exp_data));
            check({tag, " stall_id"}, 64'(rsp_id), 64'(t.exp_id));
            check({tag, " stall_busy"}, 64'(busy), 64'h1);
            check({tag, " stall_ready"}, 64'({req1_ready, req0_ready}), 64'h0);
        end
        rsp_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, " done_valid"}, 64'(rsp_valid), 64'h0);
        check({tag, " done_busy"}, 64'(busy), 64'h0);
        last_m = t.exp_id;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        tbl[0]  = '{1'b1, 1'b0, 12'h005, 12'h000, 1'b0, 1'b0, 0, 1'b0, 32'h00000005};
        tbl[1]  = '{1'b0, 1'b1, 12'h000, 12'hFFB, 1'b0, 1'b1, 0, 1'b1, 32'h00000005};
        tbl[2]  = '{1'b0, 1'b1, 12'h000, 12'hFFB, 1'b0, 1'b0, 0, 1'b1, 32'hFFFFFFFB};
        tbl[3]  = '{1'b1, 1'b1, 12'h00C, 12'hFF4, 1'b1, 1'b1, 0, 1'b0, 32'hFFFFFFF4};
        tbl[4]  = '{1'b1, 1'b1, 12'h00C, 12'hFF4, 1'b1, 1'b1, 0, 1'b1, 32'h0000000C};
        tbl[5]  = '{1'b1, 1'b1, 12'h00C, 12'hFF4, 1'b1, 1'b1, 0, 1'b0, 32'hFFFFFFF4};
        tbl[6]  = '{1'b1, 1'b1, 12'h00C, 12'hFF4, 1'b1, 1'b1, 0, 1'b1, 32'h0000000C};
        tbl[7]  = '{1'b1, 1'b0, 12'h800, 12'h000, 1'b1, 1'b0, 0, 1'b0, 32'h00000800};
        tbl[8]  = '{1'b0, 1'b1, 12'h000, 12'h7FF, 1'b0, 1'b0, 5, 1'b1, 32'h000007FF};
        tbl[9]  = '{1'b1, 1'b0, 12'h539, 12'h000, 1'b0, 1'b0, 0, 1'b0, 32'h00000539};
        tbl[10] = '{1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 0, 1'b0, 32'h00000000};
        tbl[11] = '{1'b0, 1'b1, 12'h000, 12'h001, 1'b0, 1'b1, 2, 1'b1, 32'hFFFFFFFF};

        rst        = 1'b1;
        req0_valid = 1'b0;  req0_imm = '0;  req0_neg = 1'b0;
        req1_valid = 1'b0;  req1_imm = '0;  req1_neg = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset rsp_data", 64'(rsp_data), 64'h0);
        check("reset rsp_id", 64'(rsp_id), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
`ifdef IMM_ARB_SELF_CHECK_EN
        check("reset chk_err", 64'(chk_err), 64'h0);
`endif
        // Pointer resets to 1: requester 0 wins the first contention.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("reset rr_ptr", 64'({req1_ready, req0_ready}), 64'h1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_m = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_round($sformatf("row%0d", i), tbl[i]);
        end

        // Reset while in NEG: request is dropped, no response ever appears.
        req0_valid = 1'b1;  req0_imm = 12'h003;  req0_neg = 1'b1;
        rsp_ready  = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("midrst busy_neg", 64'(busy), 64'h1);
        rst        = 1'b1;
        req0_valid = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst busy", 64'(busy), 64'h0);
        check("midrst req0_ready", 64'(req0_ready), 64'h1);
        req0_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst no_rsp", 64'(rsp_valid), 64'h0);
        end
        last_m = 1'b1;

        for (int n = 0; n < 200; n++) begin
            r.v0 = 1'($urandom_range(0, 1));
            r.v1 = 1'($urandom_range(0, 1));
            if (!r.v0 && !r.v1) r.v1 = 1'b1;
            r.i0 = IMM_W'($urandom());
            r.i1 = IMM_W'($urandom());
            if ($urandom_range(0, 3) == 0) r.i0 = 12'h800;
            if ($urandom_range(0, 3) == 0) r.i1 = 12'h7FF;
            if ($urandom_range(0, 7) == 0) r.i0 = 12'h000;
            r.n0    = 1'($urandom_range(0, 1));
            r.n1    = 1'($urandom_range(0, 1));
            r.stall = int'($urandom_range(0, 3));
            r.exp_id   = (r.v0 && r.v1) ? ~last_m : r.v1;
            r.exp_data = r.exp_id ? model(r.i1, r.n1) : model(r.i0, r.n0);
            run_round($sformatf("rnd%0d", n), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
